// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
//  - stage_state_e : occupancy of one stage (empty / main only / main + skid)
//  - per-stage control field widths and the NOP control encodings that each
//    stage passes as CTRL_NOP, chosen so every enable field decodes inactive.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Control field widths carried through the pipeline.
    localparam int ALU_OP_W   = 5;
    localparam int MEM_OP_W   = 3;
    localparam int WB_SEL_W   = 2;
    localparam int IMM_SEL_W  = 3;

    localparam int IFID_CTRL_W  = 16;
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_CTRL_W = 16;
    localparam int MEMWB_CTRL_W = 16;

    // Bubble encodings: every write/enable bit is zero, op fields select
    // a harmless default.
    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_NOP  = 16'h0000;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = 16'h0000;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = 16'h0000;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = 16'h0000;

endpackage

// File: rtl/pipe_slot_reg.sv
// One storage slot of a pipeline stage: a valid flag plus payload and control.
// Ports:
//  CLK, RESET           clock, synchronous active-high reset
//  clear                drop the entry (valid -> 0, payload held)
//  load                 capture load_data/load_ctrl and mark valid
//  load_data/load_ctrl  value captured on load
//  valid, data, ctrl    registered slot contents
// clear wins over load; RESET wins over both and zeroes the contents.
module pipe_slot_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (clear) begin
            // Payload is left as-is so the output stays defined but quiet.
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            ctrl_reg  <= load_ctrl;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// A main slot presents the oldest entry; with SKID=1 a second skid slot
// absorbs one extra entry so IN_READY can be a register.
// Ports:
//  CLK, RESET                      clock, synchronous active-high reset
//  FLUSH                           drop everything held and incoming
//  IN_VALID/IN_READY/IN_DATA/IN_CTRL      upstream handshake + payload
//  OUT_VALID/OUT_READY/OUT_DATA/OUT_CTRL  downstream handshake + payload
//  OUT_COUNT                       number of entries held (0..2)
// OUT_CTRL shows CTRL_NOP whenever OUT_VALID is low.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit              SKID     = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OUT_COUNT
);

    stage_state_e state_reg;
    stage_state_e state_next;

    logic              in_fire;
    logic              out_fire;

    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic [DATA_W-1:0] main_load_data;
    logic [CTRL_W-1:0] main_load_ctrl;

    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = main_valid & OUT_READY;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and slot controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (FLUSH) begin
            // Anything accepted this cycle is dropped along with held entries.
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Main slot refills from the skid slot when draining FULL, else upstream.
    assign main_load_data = main_from_skid ? skid_data : IN_DATA;
    assign main_load_ctrl = main_from_skid ? skid_ctrl : IN_CTRL;

    pipe_slot_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_load_data),
        .load_ctrl (main_load_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_reg;

            pipe_slot_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .CLK       (CLK),
                .RESET     (RESET),
                .clear     (skid_clear),
                .load      (skid_load),
                .load_data (IN_DATA),
                .load_ctrl (IN_CTRL),
                .valid     (skid_valid),
                .data      (skid_data),
                .ctrl      (skid_ctrl)
            );

            // Registered from the next state so upstream sees no
            // combinational path from OUT_READY.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            assign IN_READY = in_ready_reg;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign IN_READY   = OUT_READY | ~main_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: bubbles never expose stale control
    // ------------------------------------------------------------------
    assign OUT_VALID = main_valid;
    assign OUT_DATA  = main_data;
    assign OUT_CTRL  = main_valid ? main_ctrl : CTRL_NOP;
    assign OUT_COUNT = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
